// File: rtl/demux_1to2_tdm_if.sv
// Bus bundle for the 1-to-2 demux: input stream, two output channels and frame-sync error flag.
interface demux_1to2_tdm_if #(
    parameter int unsigned WIDTH = 1
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_sync;
    logic             in_ready;
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;
    logic             frame_err;

    modport master (
        output in_valid, in_data, in_sel, in_sync, a_ready, b_ready,
        input  in_ready, a_valid, a_data, b_valid, b_data, frame_err
    );

    modport slave (
        input  in_valid, in_data, in_sel, in_sync, a_ready, b_ready,
        output in_ready, a_valid, a_data, b_valid, b_data, frame_err
    );
endinterface

// File: rtl/demux_1to2_tdm.sv
// Registered 1-to-2 stream demux routed by select bit or TDM slot, with a one-entry
// holding register per channel and a sticky frame-sync misalignment flag.
module demux_1to2_tdm #(
    parameter int unsigned WIDTH = 1,
    parameter bit          TDM   = 1'b0
) (
    input logic             clk,
    input logic             rst,
    demux_1to2_tdm_if.slave bus
);
    typedef enum logic {
        SLOT_A = 1'b0,
        SLOT_B = 1'b1
    } slot_e;

    slot_e            slot_q;
    slot_e            slot_d;
    logic             a_valid_q;
    logic             a_valid_d;
    logic             b_valid_q;
    logic             b_valid_d;
    logic [WIDTH-1:0] a_data_q;
    logic [WIDTH-1:0] a_data_d;
    logic [WIDTH-1:0] b_data_q;
    logic [WIDTH-1:0] b_data_d;
    logic             ferr_q;
    logic             ferr_d;
    logic             sel_eff;
    logic             in_ready_c;
    logic             accept;

    // Destination of the beat on the bus; a sync beat always opens a frame on A.
    always_comb begin
        sel_eff = bus.in_sel;
        if (TDM) begin
            sel_eff = bus.in_sync ? 1'b0 : (slot_q == SLOT_B);
        end
    end

    // Ready looks only at the targeted channel so a stalled peer never blocks it.
    assign in_ready_c = !rst && (sel_eff ? (!b_valid_q || bus.b_ready)
                                         : (!a_valid_q || bus.a_ready));
    assign accept     = bus.in_valid && in_ready_c;

    always_comb begin
        a_valid_d = a_valid_q;
        b_valid_d = b_valid_q;
        a_data_d  = a_data_q;
        b_data_d  = b_data_q;
        slot_d    = slot_q;
        ferr_d    = ferr_q;

        if (a_valid_q && bus.a_ready) begin
            a_valid_d = 1'b0;
        end
        if (b_valid_q && bus.b_ready) begin
            b_valid_d = 1'b0;
        end

        // A load in the drain cycle overrides the clear, giving back-to-back beats.
        if (accept && !sel_eff) begin
            a_valid_d = 1'b1;
            a_data_d  = bus.in_data;
        end
        if (accept && sel_eff) begin
            b_valid_d = 1'b1;
            b_data_d  = bus.in_data;
        end

        if (TDM && accept) begin
            slot_d = sel_eff ? SLOT_A : SLOT_B;
            if (bus.in_sync && (slot_q == SLOT_B)) begin
                ferr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            a_data_q  <= '0;
            b_data_q  <= '0;
            slot_q    <= SLOT_A;
            ferr_q    <= 1'b0;
        end else begin
            a_valid_q <= a_valid_d;
            b_valid_q <= b_valid_d;
            a_data_q  <= a_data_d;
            b_data_q  <= b_data_d;
            slot_q    <= slot_d;
            ferr_q    <= ferr_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.a_valid   = a_valid_q;
    assign bus.a_data    = a_data_q;
    assign bus.b_valid   = b_valid_q;
    assign bus.b_data    = b_data_q;
    assign bus.frame_err = ferr_q;
endmodule

// File: tb/tb_demux_1to2_tdm.sv
// Scoreboard bench for demux_1to2_tdm: one instance in select mode, one in TDM mode.
module tb_demux_1to2_tdm;
    localparam int unsigned W = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    demux_1to2_tdm_if #(.WIDTH(W)) bus0 ();
    demux_1to2_tdm_if #(.WIDTH(W)) bus1 ();

    demux_1to2_tdm #(.WIDTH(W), .TDM(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    demux_1to2_tdm #(.WIDTH(W), .TDM(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    // Expected channel contents, one queue per channel per instance.
    logic qa0[$];
    logic qb0[$];
    logic qa1[$];
    logic qb1[$];
    bit   live[2];
    bit   exp_slot[2];
    bit   exp_ferr[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int qsize(input int d, input bit ch);
        case ({d[0], ch})
            2'b00:   return qa0.size();
            2'b01:   return qb0.size();
            2'b10:   return qa1.size();
            default: return qb1.size();
        endcase
    endfunction

    function automatic logic qfront(input int d, input bit ch);
        case ({d[0], ch})
            2'b00:   return qa0[0];
            2'b01:   return qb0[0];
            2'b10:   return qa1[0];
            default: return qb1[0];
        endcase
    endfunction

    task automatic qpop(input int d, input bit ch);
        case ({d[0], ch})
            2'b00:   qa0.delete(0);
            2'b01:   qb0.delete(0);
            2'b10:   qa1.delete(0);
            default: qb1.delete(0);
        endcase
    endtask

    task automatic qpush(input int d, input bit ch, input logic v);
        case ({d[0], ch})
            2'b00:   qa0.push_back(v);
            2'b01:   qb0.push_back(v);
            2'b10:   qa1.push_back(v);
            default: qb1.push_back(v);
        endcase
    endtask

    task automatic qclear(input int d);
        if (d == 0) begin
            qa0.delete();
            qb0.delete();
        end else begin
            qa1.delete();
            qb1.delete();
        end
    endtask

    // Sampled on the falling edge: compare outputs, then apply this cycle's handshakes.
    task automatic observe(input int d, input logic r, input logic iv, input logic id,
                           input logic sel, input logic sync, input logic ir,
                           input logic av, input logic ad, input logic ar,
                           input logic bv, input logic bd, input logic br, input logic fe);
        bit    tdm;
        bit    tgt;
        bit    ea;
        bit    eb;
        bit    exp_rdy;
        string p;
        tdm = (d == 1);
        p   = $sformatf("d%0d_", d);
        ea  = qsize(d, 1'b0) != 0;
        eb  = qsize(d, 1'b1) != 0;
        if (live[d]) begin
            check({p, "a_valid"}, 32'(av), 32'(ea));
            if (ea) check({p, "a_data"}, 32'(ad), 32'(qfront(d, 1'b0)));
            check({p, "b_valid"}, 32'(bv), 32'(eb));
            if (eb) check({p, "b_data"}, 32'(bd), 32'(qfront(d, 1'b1)));
            check({p, "frame_err"}, 32'(fe), 32'(exp_ferr[d]));
        end
        tgt     = tdm ? (sync ? 1'b0 : exp_slot[d]) : sel;
        exp_rdy = !r && (tgt ? (!eb || br) : (!ea || ar));
        if (live[d] || r) check({p, "in_ready"}, 32'(ir), 32'(exp_rdy));
        if (r) begin
            qclear(d);
            exp_slot[d] = 1'b0;
            exp_ferr[d] = 1'b0;
            live[d]     = 1'b1;
        end else if (live[d]) begin
            if (ea && ar) qpop(d, 1'b0);
            if (eb && br) qpop(d, 1'b1);
            if (iv && exp_rdy) begin
                if (tdm && sync && exp_slot[d]) exp_ferr[d] = 1'b1;
                qpush(d, tgt, id);
                if (tdm) exp_slot[d] = !tgt;
            end
        end
    endtask

    always @(negedge clk) begin
        observe(0, rst, bus0.in_valid, bus0.in_data, bus0.in_sel, bus0.in_sync, bus0.in_ready,
                bus0.a_valid, bus0.a_data, bus0.a_ready, bus0.b_valid, bus0.b_data,
                bus0.b_ready, bus0.frame_err);
        observe(1, rst, bus1.in_valid, bus1.in_data, bus1.in_sel, bus1.in_sync, bus1.in_ready,
                bus1.a_valid, bus1.a_data, bus1.a_ready, bus1.b_valid, bus1.b_data,
                bus1.b_ready, bus1.frame_err);
    end

    task automatic drive(input int d, input logic v, input logic sel, input logic sync,
                         input logic data);
        if (d == 0) begin
            bus0.in_valid = v;
            bus0.in_sel   = sel;
            bus0.in_sync  = sync;
            bus0.in_data  = data;
        end else begin
            bus1.in_valid = v;
            bus1.in_sel   = sel;
            bus1.in_sync  = sync;
            bus1.in_data  = data;
        end
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? bus0.in_ready : bus1.in_ready;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a beat and hold it until accepted; returns just after the accepting edge.
    task automatic send(input int d, input logic sel, input logic sync, input logic data);
        int n;
        n = 0;
        drive(d, 1'b1, sel, sync, data);
        @(negedge clk);
        while (rdy(d) !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_timeout", 32'(n < 50), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus0.a_ready = 1'b1;
        bus0.b_ready = 1'b1;
        bus1.a_ready = 1'b1;
        bus1.b_ready = 1'b1;

        // Reset held two cycles with beats presented.
        rst = 1'b1;
        drive(0, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(1, 1'b1, 1'b0, 1'b1, 1'b1);
        cycles(2);
        check("rst_a_valid", 32'(bus0.a_valid), 32'd0);
        check("rst_b_valid", 32'(bus0.b_valid), 32'd0);
        check("rst_a_data", 32'(bus0.a_data), 32'd0);
        check("rst_b_data", 32'(bus0.b_data), 32'd0);
        check("rst_in_ready", 32'(bus0.in_ready), 32'd0);
        check("rst_frame_err", 32'(bus1.frame_err), 32'd0);
        check("rst_tdm_in_ready", 32'(bus1.in_ready), 32'd0);
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycles(3);

        // Select routing at full rate.
        send(0, 1'b0, 1'b0, 1'b1);
        check("sel_lat_a_valid", 32'(bus0.a_valid), 32'd1);
        check("sel_lat_a_data", 32'(bus0.a_data), 32'd1);
        send(0, 1'b1, 1'b0, 1'b0);
        check("sel_lat_b_valid", 32'(bus0.b_valid), 32'd1);
        send(0, 1'b0, 1'b0, 1'b0);
        send(0, 1'b1, 1'b0, 1'b1);
        check("sel_lat_b_data", 32'(bus0.b_data), 32'd1);
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycles(3);

        // Stall isolation: A blocked, B keeps flowing.
        bus0.a_ready = 1'b0;
        send(0, 1'b0, 1'b0, 1'b1);
        send(0, 1'b1, 1'b0, 1'b0);
        send(0, 1'b1, 1'b0, 1'b1);
        drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", 32'(bus0.in_ready), 32'd0);
            check("stall_a_data", 32'(bus0.a_data), 32'd1);
        end
        @(posedge clk);
        #1;
        bus0.a_ready = 1'b1;
        @(negedge clk);
        check("unstall_in_ready", 32'(bus0.in_ready), 32'd1);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycles(2);

        // Drain and load of A in the same cycle.
        send(0, 1'b0, 1'b0, 1'b1);
        send(0, 1'b0, 1'b0, 1'b0);
        check("dl_a_valid", 32'(bus0.a_valid), 32'd1);
        check("dl_a_data", 32'(bus0.a_data), 32'd0);
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycles(2);

        // TDM alternation starting on a sync beat.
        send(1, 1'b0, 1'b1, 1'b1);
        send(1, 1'b1, 1'b0, 1'b0);
        check("tdm_b_data", 32'(bus1.b_data), 32'd0);
        send(1, 1'b1, 1'b0, 1'b1);
        send(1, 1'b0, 1'b0, 1'b1);
        drive(1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycles(2);
        check("tdm_frame_err", 32'(bus1.frame_err), 32'd0);

        // Sync arriving mid-frame.
        send(1, 1'b0, 1'b1, 1'b1);
        send(1, 1'b0, 1'b1, 1'b0);
        check("mid_a_data", 32'(bus1.a_data), 32'd0);
        check("mid_b_valid", 32'(bus1.b_valid), 32'd0);
        check("mid_frame_err", 32'(bus1.frame_err), 32'd1);
        drive(1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycles(5);
        check("mid_frame_err_sticky", 32'(bus1.frame_err), 32'd1);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check("mid_frame_err_clr", 32'(bus1.frame_err), 32'd0);
        cycles(2);

        // TDM in-order blocking behind a stalled B.
        bus1.b_ready = 1'b0;
        send(1, 1'b0, 1'b1, 1'b1);
        send(1, 1'b0, 1'b0, 1'b0);
        send(1, 1'b0, 1'b0, 1'b1);
        drive(1, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("tdm_block_in_ready", 32'(bus1.in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus1.b_ready = 1'b1;
        @(negedge clk);
        check("tdm_unblock_in_ready", 32'(bus1.in_ready), 32'd1);
        @(posedge clk);
        #1;
        drive(1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycles(2);

        // Random traffic on both instances against the scoreboard.
        for (int i = 0; i < 3000; i++) begin
            drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
                  1'($urandom_range(0, 1)));
            drive(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
            bus0.a_ready = ($urandom_range(0, 3) != 0);
            bus0.b_ready = ($urandom_range(0, 3) != 0);
            bus1.a_ready = ($urandom_range(0, 3) != 0);
            bus1.b_ready = ($urandom_range(0, 3) != 0);
            cycles(1);
        end
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0, 1'b0);
        bus0.a_ready = 1'b1;
        bus0.b_ready = 1'b1;
        bus1.a_ready = 1'b1;
        bus1.b_ready = 1'b1;
        cycles(4);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_drain_a", d), 32'(qsize(d, 1'b0)), 32'd0);
            check($sformatf("d%0d_drain_b", d), 32'(qsize(d, 1'b1)), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
